cache_set_ctrl: RTL and testbench

- Parametrised N-way set-associative cache set with true-LRU replacement.
- Services byte read/write requests through a valid/ready front end.
- On a miss, writes back a dirty victim and refills the line word by word over a req/ack memory handshake.
- Sits between the cache controller (which selects the set from index bits) and the memory-side port.

---
 rtl/cache_set_if.sv | 37 +++
 rtl/cache_set_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cache_set_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_set_if.sv
// Cache set bundle: front-end request/response, memory beat port and
// per-way status.
//   master : request source + memory responder (drives req_*, mem_ack, mem_rdata)
//   slave  : the cache set (drives req_ready, resp_*, mem_req/we/addr/wdata, masks)
interface cache_set_if #(
  parameter int ADDRESS_WORD_SIZE = 32,
  parameter int WORD_SIZE         = 4,
  parameter int WAYS              = 4
) ();
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [ADDRESS_WORD_SIZE-1:0] req_addr;
  logic [7:0]                   req_wdata;
  logic                         resp_valid;
  logic [7:0]                   resp_data;
  logic                         resp_hit;
  logic                         mem_req;
  logic                         mem_we;
  logic [ADDRESS_WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE*8-1:0]       mem_wdata;
  logic                         mem_ack;
  logic [WORD_SIZE*8-1:0]       mem_rdata;
  logic [WAYS-1:0]              valid_mask;
  logic [WAYS-1:0]              dirty_mask;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata, valid_mask, dirty_mask
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata, valid_mask, dirty_mask
  );
endinterface

// File: rtl/cache_set_ctrl.sv
// N-way set-associative cache set with true-LRU replacement.
// Ports: clk, rst_b (synchronous, active-low), bus (cache_set_if.slave):
//   req_valid/req_ready/req_write/req_addr/req_wdata : byte request front end
//   resp_valid/resp_data/resp_hit                    : one-cycle response strobe
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata : word beat port
//   valid_mask/dirty_mask                            : per-way status
// A miss writes back a dirty victim (BLOCK_SIZE beats), refills it
// (BLOCK_SIZE beats), then re-enters COMPARE, which now hits.
module cache_set_ctrl #(
  parameter int ADDRESS_WORD_SIZE = 32,
  parameter int TAG_SIZE          = 19,
  parameter int BLOCK_SIZE        = 16,
  parameter int WORD_SIZE         = 4,
  parameter int WAYS              = 4,
  parameter int AGE_BITS          = 2
) (
  input logic       clk,
  input logic       rst_b,
  cache_set_if.slave bus
);
  localparam int BYTE_BITS = $clog2(WORD_SIZE);
  localparam int WORD_BITS = $clog2(BLOCK_SIZE);
  localparam int OFF       = BYTE_BITS + WORD_BITS;
  localparam int IDX_BITS  = ADDRESS_WORD_SIZE - TAG_SIZE - OFF;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;
  state_t state_q, state_d;

  logic [WAYS-1:0][BLOCK_SIZE-1:0][WORD_SIZE-1:0][7:0] data_q;
  logic [WAYS-1:0][TAG_SIZE-1:0] tag_q;
  logic [WAYS-1:0]               valid_q, dirty_q;
  logic [WAYS-1:0][AGE_BITS-1:0] age_q;

  logic [ADDRESS_WORD_SIZE-1:0] addr_q;
  logic                         write_q, miss_q;
  logic [7:0]                   wdata_q;
  logic [AGE_BITS-1:0]          vic_q;
  logic [WORD_BITS-1:0]         cnt_q, cnt_nxt;

  logic [TAG_SIZE-1:0]  req_tag;
  logic [IDX_BITS-1:0]  req_idx;
  logic [WORD_BITS-1:0] req_word;
  logic [BYTE_BITS-1:0] req_byte;
  assign req_tag  = addr_q[ADDRESS_WORD_SIZE-1 -: TAG_SIZE];
  assign req_idx  = addr_q[OFF +: IDX_BITS];
  assign req_word = addr_q[BYTE_BITS +: WORD_BITS];
  assign req_byte = addr_q[BYTE_BITS-1:0];

  logic                hit, found_inv, beat_done, last_beat;
  logic [AGE_BITS-1:0] hit_way, vic_way;

  assign beat_done = bus.mem_req & bus.mem_ack;
  assign last_beat = (cnt_q == WORD_BITS'(BLOCK_SIZE - 1));
  assign cnt_nxt   = cnt_q + 1'b1;

  // Lookup and victim choice: lowest invalid way first, otherwise the oldest.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    vic_way   = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[w] && tag_q[w] == req_tag) begin
        hit     = 1'b1;
        hit_way = AGE_BITS'(w);
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[w]) begin
        found_inv = 1'b1;
        vic_way   = AGE_BITS'(w);
      end
    if (!found_inv)
      for (int w = 0; w < WAYS; w++)
        if (age_q[w] == AGE_BITS'(WAYS - 1)) vic_way = AGE_BITS'(w);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.req_valid && bus.req_ready) state_d = COMPARE;
      COMPARE:   if (hit)                 state_d = IDLE;
                 else if (dirty_q[vic_way]) state_d = WRITEBACK;
                 else                     state_d = FILL;
      WRITEBACK: if (beat_done && last_beat) state_d = FILL;
      FILL:      if (beat_done && last_beat) state_d = COMPARE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Line storage carries no reset: contents are only meaningful under valid_q.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      if (state_q == COMPARE && hit && write_q)
        data_q[hit_way][req_word][req_byte] <= wdata_q;
      if (state_q == FILL && beat_done) begin
        data_q[vic_q][cnt_q] <= bus.mem_rdata;
        if (last_beat) tag_q[vic_q] <= req_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      valid_q        <= '0;
      dirty_q        <= '0;
      for (int w = 0; w < WAYS; w++) age_q[w] <= AGE_BITS'(w);
      addr_q         <= '0;
      write_q        <= 1'b0;
      wdata_q        <= '0;
      miss_q         <= 1'b0;
      vic_q          <= '0;
      cnt_q          <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_hit   <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.req_ready  <= (state_d == IDLE);
      case (state_q)
        IDLE: if (bus.req_valid && bus.req_ready) begin
          addr_q  <= bus.req_addr;
          write_q <= bus.req_write;
          wdata_q <= bus.req_wdata;
          miss_q  <= 1'b0;
        end
        COMPARE: if (hit) begin
          bus.resp_valid <= 1'b1;
          bus.resp_hit   <= !miss_q;
          if (write_q) begin
            dirty_q[hit_way] <= 1'b1;
            bus.resp_data    <= wdata_q;
          end else begin
            bus.resp_data    <= data_q[hit_way][req_word][req_byte];
          end
          // Ages stay a permutation: only younger ways shift up.
          for (int w = 0; w < WAYS; w++)
            if (age_q[w] < age_q[hit_way]) age_q[w] <= age_q[w] + 1'b1;
          age_q[hit_way] <= '0;
        end else begin
          miss_q      <= 1'b1;
          vic_q       <= vic_way;
          cnt_q       <= '0;
          bus.mem_req <= 1'b1;
          if (dirty_q[vic_way]) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= {tag_q[vic_way], req_idx, {OFF{1'b0}}};
            bus.mem_wdata <= data_q[vic_way][0];
          end else begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {req_tag, req_idx, {OFF{1'b0}}};
          end
        end
        WRITEBACK: if (beat_done) begin
          cnt_q <= cnt_nxt;
          if (last_beat) begin
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= {req_tag, req_idx, {OFF{1'b0}}};
          end else begin
            bus.mem_addr  <= {tag_q[vic_q], req_idx, cnt_nxt, {BYTE_BITS{1'b0}}};
            bus.mem_wdata <= data_q[vic_q][cnt_nxt];
          end
        end
        FILL: if (beat_done) begin
          cnt_q <= cnt_nxt;
          if (last_beat) begin
            bus.mem_req    <= 1'b0;
            valid_q[vic_q] <= 1'b1;
            dirty_q[vic_q] <= 1'b0;
          end else begin
            bus.mem_addr <= {req_tag, req_idx, cnt_nxt, {BYTE_BITS{1'b0}}};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.valid_mask = valid_q;
  assign bus.dirty_mask = dirty_q;
endmodule

// File: tb/tb_cache_set_ctrl.sv
// Bench for cache_set_ctrl: table of requests with expected response,
// beat counts, beat base addresses and masks; plus hand sequences for
// writeback data, reset mid-fill and a stalled memory with a busy request.
module tb_cache_set_ctrl;
  logic clk = 1'b0, rst_b = 1'b0;
  always #5 clk = ~clk;

  cache_set_if #(.ADDRESS_WORD_SIZE(32), .WORD_SIZE(4), .WAYS(4)) bus ();
  cache_set_ctrl #(.ADDRESS_WORD_SIZE(32), .TAG_SIZE(19), .BLOCK_SIZE(16),
                   .WORD_SIZE(4), .WAYS(4), .AGE_BITS(2))
    dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  typedef struct {
    bit rst; int stall; bit wr; logic [31:0] addr; logic [7:0] wdata;
    logic [7:0] exp_data; bit exp_hit;
    int exp_wb; logic [31:0] wb_base; int exp_fill; logic [31:0] fill_base;
    logic [3:0] exp_valid; logic [3:0] exp_dirty;
  } vec_t;
  typedef struct { logic [7:0] data; bit hit; } resp_t;

  resp_t       exp_q[$];
  vec_t        vt[17];
  int          checks = 0, failures = 0;
  int          cyc = 0, resp_seen = 0, resp_cyc = 0;
  int          stall_cfg = 0, stall_cnt = 0, wb_cnt = 0, fill_cnt = 0;
  bit          stalling = 0;
  logic [31:0] st_addr, st_wdata, wb_base = '0, fill_base = '0;
  logic        st_we;
  logic [31:0] wb_data[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard.
  always @(negedge clk) begin
    resp_t e;
    if (rst_b && bus.resp_valid) begin
      resp_seen++;
      resp_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_resp", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("resp_data", bus.resp_data, e.data);
        check("resp_hit", bus.resp_hit, e.hit);
      end
    end
  end

  // Memory: returns {4{beat}} per word, optional stall per beat, checks
  // beat addresses in order and stability while stalled.
  always @(negedge clk) begin
    if (!rst_b) begin
      bus.mem_ack = 1'b0; stall_cnt = 0; stalling = 0;
    end else if (bus.mem_req) begin
      if (stalling) begin
        check("stall_addr", bus.mem_addr, st_addr);
        check("stall_wdata", bus.mem_wdata, st_wdata);
        check("stall_we", bus.mem_we, st_we);
      end
      if (stall_cnt < stall_cfg) begin
        bus.mem_ack = 1'b0; stall_cnt++; stalling = 1;
        st_addr = bus.mem_addr; st_wdata = bus.mem_wdata; st_we = bus.mem_we;
      end else begin
        bus.mem_ack = 1'b1; stall_cnt = 0; stalling = 0;
        bus.mem_rdata = {4{4'h0, bus.mem_addr[5:2]}};
        if (bus.mem_we) begin
          check("wb_addr", bus.mem_addr, wb_base + 32'(4 * wb_cnt));
          if (wb_cnt < 16) wb_data[wb_cnt] = bus.mem_wdata;
          wb_cnt++;
        end else begin
          check("fill_addr", bus.mem_addr, fill_base + 32'(4 * fill_cnt));
          fill_cnt++;
        end
      end
    end else begin
      bus.mem_ack = 1'b0; stalling = 0;
    end
  end

  task automatic step;
    @(negedge clk); #1;
  endtask

  task automatic do_reset;
    step; rst_b = 1'b0; bus.req_valid = 1'b0;
    repeat (2) step;
    rst_b = 1'b1; exp_q.delete();
  endtask

  task automatic send(input bit wr, input logic [31:0] a, input logic [7:0] d, output int c0);
    int t;
    t = 0;
    while (!bus.req_ready && t < 1000) begin step; t++; end
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
    c0 = cyc;
    step;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string nm, input int seen0);
    int t;
    t = 0;
    while (resp_seen == seen0 && t < 2000) begin step; t++; end
    check({nm, "_timeout"}, resp_seen == seen0, 0);
    if (resp_seen == seen0) exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int c0, seen0;
    if (v.rst) do_reset;
    stall_cfg = v.stall; wb_cnt = 0; fill_cnt = 0;
    wb_base = v.wb_base; fill_base = v.fill_base;
    exp_q.push_back('{v.exp_data, v.exp_hit});
    seen0 = resp_seen;
    send(v.wr, v.addr, v.wdata, c0);
    wait_resp(nm, seen0);
    if (v.exp_hit) check({nm, "_latency"}, resp_cyc - c0, 2);
    check({nm, "_wb_beats"}, wb_cnt, v.exp_wb);
    check({nm, "_fill_beats"}, fill_cnt, v.exp_fill);
    check({nm, "_valid_mask"}, bus.valid_mask, v.exp_valid);
    check({nm, "_dirty_mask"}, bus.dirty_mask, v.exp_dirty);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int c0, seen0, t;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    //             rst stl wr addr          wd     data   hit wb  wb_base       fill fill_base    valid    dirty
    vt[0]  = '{1, 0, 0, 32'hA000_0044, 8'h00, 8'h01, 0, 0,  32'h0,        16, 32'hA000_0040, 4'b0001, 4'b0000};
    vt[1]  = '{0, 0, 1, 32'hA000_0046, 8'h5A, 8'h5A, 1, 0,  32'h0,        0,  32'h0,         4'b0001, 4'b0001};
    vt[2]  = '{0, 0, 0, 32'hB000_0040, 8'h00, 8'h00, 0, 0,  32'h0,        16, 32'hB000_0040, 4'b0011, 4'b0001};
    vt[3]  = '{0, 3, 0, 32'hC000_0040, 8'h00, 8'h00, 0, 0,  32'h0,        16, 32'hC000_0040, 4'b0111, 4'b0001};
    vt[4]  = '{0, 0, 0, 32'hD000_0040, 8'h00, 8'h00, 0, 0,  32'h0,        16, 32'hD000_0040, 4'b1111, 4'b0001};
    vt[5]  = '{0, 3, 0, 32'hE000_0040, 8'h00, 8'h00, 0, 16, 32'hA000_0040, 16, 32'hE000_0040, 4'b1111, 4'b0000};
    vt[6]  = '{0, 0, 0, 32'hE000_0046, 8'h00, 8'h01, 1, 0,  32'h0,        0,  32'h0,         4'b1111, 4'b0000};
    vt[7]  = '{1, 0, 0, 32'h1000_0000, 8'h00, 8'h00, 0, 0,  32'h0,        16, 32'h1000_0000, 4'b0001, 4'b0000};
    vt[8]  = '{0, 0, 0, 32'h2000_0000, 8'h00, 8'h00, 0, 0,  32'h0,        16, 32'h2000_0000, 4'b0011, 4'b0000};
    vt[9]  = '{0, 0, 0, 32'h3000_0000, 8'h00, 8'h00, 0, 0,  32'h0,        16, 32'h3000_0000, 4'b0111, 4'b0000};
    vt[10] = '{0, 0, 0, 32'h4000_0000, 8'h00, 8'h00, 0, 0,  32'h0,        16, 32'h4000_0000, 4'b1111, 4'b0000};
    vt[11] = '{0, 0, 0, 32'h1000_0008, 8'h00, 8'h02, 1, 0,  32'h0,        0,  32'h0,         4'b1111, 4'b0000};
    vt[12] = '{0, 0, 0, 32'h5000_0000, 8'h00, 8'h00, 0, 0,  32'h0,        16, 32'h5000_0000, 4'b1111, 4'b0000};
    vt[13] = '{0, 0, 0, 32'h1000_0000, 8'h00, 8'h00, 1, 0,  32'h0,        0,  32'h0,         4'b1111, 4'b0000};
    vt[14] = '{0, 0, 0, 32'h2000_0000, 8'h00, 8'h00, 0, 0,  32'h0,        16, 32'h2000_0000, 4'b1111, 4'b0000};
    vt[15] = '{0, 0, 1, 32'h1000_0001, 8'h33, 8'h33, 1, 0,  32'h0,        0,  32'h0,         4'b1111, 4'b0001};
    vt[16] = '{0, 0, 0, 32'h9000_0000, 8'h00, 8'h00, 0, 0,  32'h0,        16, 32'h9000_0000, 4'b0001, 4'b0000};

    // Reset state.
    do_reset;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_valid_mask", bus.valid_mask, 0);
    check("rst_dirty_mask", bus.dirty_mask, 0);

    // Cold read, write hit, dirty eviction of way0.
    for (int i = 0; i <= 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));
    check("wb_beat0", wb_data[0], 32'h0000_0000);
    check("wb_beat1", wb_data[1], 32'h015A_0101);
    check("wb_beat15", wb_data[15], 32'h0F0F_0F0F);

    // LRU: re-read way0 makes way1 oldest; 2000_0000 then misses.
    for (int i = 7; i <= 15; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset during a fill: nothing installed, all state cleared.
    stall_cfg = 0; wb_cnt = 0; fill_cnt = 0; fill_base = 32'h9000_0000;
    send(1'b0, 32'h9000_0000, 8'h00, c0);
    t = 0;
    while (fill_cnt < 7 && t < 500) begin step; t++; end
    check("rmf_reached_beat7", fill_cnt >= 7, 1);
    rst_b = 1'b0;
    step;
    check("rmf_mem_req", bus.mem_req, 0);
    check("rmf_req_ready", bus.req_ready, 1);
    check("rmf_valid_mask", bus.valid_mask, 0);
    check("rmf_dirty_mask", bus.dirty_mask, 0);
    check("rmf_resp_valid", bus.resp_valid, 0);
    rst_b = 1'b1; exp_q.delete();
    step;
    run_vec(vt[16], "vec16");

    // Stalled memory with a request pulsed while busy.
    stall_cfg = 3; wb_cnt = 0; fill_cnt = 0; fill_base = 32'h6000_0080;
    exp_q.push_back('{8'h01, 1'b0});
    seen0 = resp_seen;
    send(1'b0, 32'h6000_0084, 8'h00, c0);
    repeat (20) step;
    check("busy_req_ready", bus.req_ready, 0);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h7000_0000; bus.req_wdata = 8'hEE;
    step;
    bus.req_valid = 1'b0;
    wait_resp("stall", seen0);
    check("stall_fill_beats", fill_cnt, 16);
    check("stall_wb_beats", wb_cnt, 0);
    repeat (10) step;
    check("busy_req_ignored", resp_seen, seen0 + 1);
    check("stall_valid_mask", bus.valid_mask, 4'b0011);
    check("stall_mem_req_idle", bus.mem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
